// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with mid-bit sampling, configurable frame format,
// per-frame parity/framing status and a single-entry valid/ready holding register.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_en,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            sync_q, sync_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  perr_acc_q, perr_acc_d;
    logic                  ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0]  dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;
    logic                  busy_q, busy_d;

    logic                  rxs;
    logic                  mid_tick;
    logic                  full_tick;
    logic                  commit;
    logic                  commit_ferr;

    // Even parity fails on an odd count of ones over data+parity; odd parity the reverse.
    function automatic logic parity_fail(input logic [DATA_BITS-1:0] data, input logic pbit);
        logic odd_ones;
        odd_ones = ^{data, pbit};
        return (PARITY == 2) ? ~odd_ones : odd_ones;
    endfunction

    assign rxs       = sync_q[1];
    assign mid_tick  = (tick_q == TICK_MID);
    assign full_tick = (tick_q == TICK_LAST);

    always_comb begin
        sync_d      = {sync_q[0], rx_in};
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        perr_acc_d  = perr_acc_q;
        ferr_acc_d  = ferr_acc_q;
        commit      = 1'b0;
        commit_ferr = ferr_acc_q;

        if (sample_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        state_d = S_START;
                        tick_d  = '0;
                    end
                end
                S_START: begin
                    if (mid_tick) begin
                        // From here on, every OVERSAMPLE ticks lands on the middle of a bit.
                        tick_d     = '0;
                        bit_d      = '0;
                        perr_acc_d = 1'b0;
                        ferr_acc_d = 1'b0;
                        state_d    = rxs ? S_IDLE : S_DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (full_tick) begin
                        tick_d  = '0;
                        shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
                        if (bit_q == DATA_LAST) begin
                            bit_d   = '0;
                            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (full_tick) begin
                        tick_d     = '0;
                        perr_acc_d = parity_fail(shreg_q, rxs);
                        state_d    = S_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (full_tick) begin
                        tick_d = '0;
                        if (!rxs) begin
                            ferr_acc_d = 1'b1;
                        end
                        if (bit_q == STOP_LAST) begin
                            bit_d       = '0;
                            commit      = 1'b1;
                            commit_ferr = ferr_acc_q | ~rxs;
                            state_d     = rxs ? S_IDLE : S_BREAK;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rxs) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;
        busy_d  = (state_d != S_IDLE);

        // A pop on the commit edge frees the holding register in time for the new frame.
        if (commit) begin
            if (!valid_q || dout_ready) begin
                dout_d  = shreg_q;
                perr_d  = perr_acc_q;
                ferr_d  = commit_ferr;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q     <= 2'b11;
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            perr_acc_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            perr_acc_q <= perr_acc_d;
            ferr_acc_q <= ferr_acc_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: one default receiver (8E1, x16) and one 7O2 x8 receiver,
// directed scenarios followed by randomized frames checked against a frame-level model.
module tb_uart_rx_param;

    localparam int OS_A = 16;
    localparam int OS_B = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       sample_en = 1'b0;
    logic       rst_n_a, rx_a, ready_drv_a, ready_a;
    logic [7:0] dout_a;
    logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;
    logic       rst_n_b, rx_b, ready_b;
    logic [6:0] dout_b;
    logic       valid_b, perr_b, ferr_b, ovr_b, busy_b;

    logic rand_ready_en = 1'b0;
    logic rand_bit = 1'b0;
    assign ready_a = ready_drv_a | (rand_ready_en & rand_bit);

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_param dut_a (
        .clk        (clk),
        .reset      (rst_n_a),
        .sample_en  (sample_en),
        .rx_in      (rx_a),
        .dout       (dout_a),
        .dout_valid (valid_a),
        .dout_ready (ready_a),
        .parity_err (perr_a),
        .frame_err  (ferr_a),
        .overrun    (ovr_a),
        .busy       (busy_a)
    );

    uart_rx_param #(
        .DATA_BITS  (7),
        .PARITY     (2),
        .STOP_BITS  (2),
        .OVERSAMPLE (OS_B)
    ) dut_b (
        .clk        (clk),
        .reset      (rst_n_b),
        .sample_en  (sample_en),
        .rx_in      (rx_b),
        .dout       (dout_b),
        .dout_valid (valid_b),
        .dout_ready (ready_b),
        .parity_err (perr_b),
        .frame_err  (ferr_b),
        .overrun    (ovr_b),
        .busy       (busy_b)
    );

    // sample_en: one clock in four
    initial begin : sample_gen
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            cnt = (cnt + 1) % 4;
            sample_en = (cnt == 0);
        end
    end

    initial begin : rand_gen
        forever begin
            @(negedge clk);
            rand_bit = 1'($urandom_range(0, 1));
        end
    end

    // Monitors: record every accepted frame and overrun pulses
    logic [10:0] pop_q_a[$];
    logic [10:0] pop_q_b[$];
    int ovr_cnt_a = 0, ovr_run_a = 0, ovr_max_a = 0;
    int ovr_cnt_b = 0;

    always begin
        @(negedge clk);
        #1;
        if (valid_a === 1'b1 && ready_a === 1'b1) pop_q_a.push_back({perr_a, ferr_a, 1'b0, dout_a});
        if (ovr_a === 1'b1) begin
            ovr_cnt_a++;
            ovr_run_a++;
            if (ovr_run_a > ovr_max_a) ovr_max_a = ovr_run_a;
        end else begin
            ovr_run_a = 0;
        end
    end

    always begin
        @(negedge clk);
        #1;
        if (valid_b === 1'b1 && ready_b === 1'b1) pop_q_b.push_back({perr_b, ferr_b, 2'b00, dout_b});
        if (ovr_b === 1'b1) ovr_cnt_b++;
    end

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation still running after 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (sample_en !== 1'b1);
        end
    endtask

    task automatic drive_line(input int which, input logic v);
        @(negedge clk);
        if (which == 0) rx_a = v;
        else rx_b = v;
    endtask

    task automatic set_ready(input int which, input logic v);
        if (which == 0) ready_drv_a = v;
        else ready_b = v;
    endtask

    // Frame-level model: the parity bit that makes a frame clean, and the error a given one gives
    function automatic int count_ones(input logic [8:0] data, input int nb);
        int ones;
        ones = 0;
        for (int i = 0; i < nb; i++) ones += int'(data[i]);
        return ones;
    endfunction

    function automatic logic good_par(input logic [8:0] data, input int nb, input int mode);
        int ones;
        ones = count_ones(data, nb);
        return (mode == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
    endfunction

    function automatic logic model_perr(input logic [8:0] data, input int nb, input int mode,
                                        input logic pbit);
        int total;
        total = count_ones(data, nb) + int'(pbit);
        if (mode == 0) return 1'b0;
        return (mode == 1) ? ((total % 2) == 1) : ((total % 2) == 0);
    endfunction

    // Sends one frame; commit_pulse raises ready for exactly the clock of the last stop sample
    task automatic send(input int which, input logic [8:0] data, input logic pbit,
                        input logic [1:0] stops, input bit commit_pulse);
        int   nb, os, ns;
        logic bits[$];
        nb = (which == 0) ? 8 : 7;
        os = (which == 0) ? OS_A : OS_B;
        ns = (which == 0) ? 1 : 2;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(data[i]);
        bits.push_back(pbit);
        for (int i = 0; i < ns; i++) bits.push_back(stops[i]);
        wait_ticks(1);
        for (int k = 0; k < bits.size(); k++) begin
            drive_line(which, bits[k]);
            if (commit_pulse && k == bits.size() - 1) begin
                wait_ticks(os / 2);
                repeat (4) @(negedge clk);
                set_ready(which, 1'b1);
                @(negedge clk);
                set_ready(which, 1'b0);
                wait_ticks(os - os / 2 - 1);
            end else begin
                wait_ticks(os);
            end
        end
    endtask

    task automatic pop(input int which, input string tag);
        @(negedge clk);
        set_ready(which, 1'b1);
        @(negedge clk);
        set_ready(which, 1'b0);
        #1;
        check(tag, (which == 0) ? valid_a : valid_b, 0);
    endtask

    task automatic check_a(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        @(negedge clk);
        #1;
        check({tag, "_valid"}, valid_a, 1);
        check({tag, "_dout"}, dout_a, d);
        check({tag, "_perr"}, perr_a, pe);
        check({tag, "_ferr"}, ferr_a, fe);
    endtask

    initial begin
        int          base, ovr0, k;
        logic [8:0]  data;
        logic        pbit, stp;
        logic [1:0]  stops;
        logic [10:0] exp_q[$];

        rst_n_a = 1'b0; rst_n_b = 1'b0;
        rx_a = 1'b1; rx_b = 1'b1;
        ready_drv_a = 1'b0; ready_b = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_dout", dout_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_perr", perr_a, 0);
        check("rst_ferr", ferr_a, 0);
        check("rst_ovr", ovr_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_b_valid", valid_b, 0);
        @(negedge clk);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        wait_ticks(4);

        send(0, 9'h0A5, 1'b0, 2'b11, 1'b0);
        check_a("a5_clean", 8'hA5, 1'b0, 1'b0);
        check("a5_busy_idle", busy_a, 0);
        pop(0, "a5_pop_valid");

        send(0, 9'h0A5, 1'b1, 2'b11, 1'b0);
        check_a("a5_badpar", 8'hA5, 1'b1, 1'b0);
        pop(0, "a5_badpar_pop");

        send(0, 9'h03C, 1'b0, 2'b00, 1'b0);
        check_a("3c_stop0", 8'h3C, 1'b0, 1'b1);
        pop(0, "3c_pop");
        wait_ticks(3 * OS_A);
        @(negedge clk);
        #1;
        check("break_busy", busy_a, 1);
        check("break_no_frame", valid_a, 0);
        drive_line(0, 1'b1);
        wait_ticks(2 * OS_A);
        @(negedge clk);
        #1;
        check("break_exit_busy", busy_a, 0);
        check("break_exit_valid", valid_a, 0);
        send(0, 9'h05A, 1'b0, 2'b11, 1'b0);
        check_a("5a_after_break", 8'h5A, 1'b0, 1'b0);
        pop(0, "5a_pop");

        ovr0 = ovr_cnt_a;
        wait_ticks(1);
        drive_line(0, 1'b0);
        wait_ticks(4);
        @(negedge clk);
        #1;
        check("false_start_busy", busy_a, 1);
        drive_line(0, 1'b1);
        wait_ticks(OS_A);
        @(negedge clk);
        #1;
        check("false_start_idle", busy_a, 0);
        check("false_start_valid", valid_a, 0);
        check("false_start_ovr", ovr_cnt_a - ovr0, 0);

        send(0, 9'h011, 1'b0, 2'b11, 1'b0);
        check_a("11_held", 8'h11, 1'b0, 1'b0);
        send(0, 9'h022, 1'b0, 2'b11, 1'b0);
        check_a("22_dropped", 8'h11, 1'b0, 1'b0);
        check("overrun_count", ovr_cnt_a - ovr0, 1);
        check("overrun_width", ovr_max_a, 1);
        pop(0, "overrun_pop");
        check("overrun_dout_kept", dout_a, 8'h11);
        send(0, 9'h044, 1'b0, 2'b11, 1'b0);
        check_a("44_held", 8'h44, 1'b0, 1'b0);
        ovr0 = ovr_cnt_a;
        send(0, 9'h033, 1'b0, 2'b11, 1'b1);
        check_a("pop_commit", 8'h33, 1'b0, 1'b0);
        check("pop_commit_ovr", ovr_cnt_a - ovr0, 0);
        pop(0, "pop_commit_pop");

        // Randomized frames on A with a randomly stalling consumer
        base = pop_q_a.size();
        ovr0 = ovr_cnt_a;
        rand_ready_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data = 9'($urandom_range(0, 255));
            pbit = good_par(data, 8, 1) ^ ($urandom_range(0, 3) == 0);
            stp  = ($urandom_range(0, 4) != 0);
            send(0, data, pbit, {1'b1, stp}, 1'b0);
            exp_q.push_back({model_perr(data, 8, 1, pbit), ~stp, data});
            if (!stp) begin
                wait_ticks($urandom_range(1, 2 * OS_A));
                drive_line(0, 1'b1);
                wait_ticks(OS_A);
            end else begin
                wait_ticks($urandom_range(0, 3));
            end
        end
        k = 0;
        while (valid_a !== 1'b0 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        rand_ready_en = 1'b0;
        check("rnd_a_count", pop_q_a.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < pop_q_a.size()) check($sformatf("rnd_a_%0d", i), pop_q_a[base + i], exp_q[i]);
        end
        check("rnd_a_ovr", ovr_cnt_a - ovr0, 0);

        // B: 7 data bits, odd parity, two stop bits
        send(1, 9'h02A, 1'b0, 2'b11, 1'b0);
        @(negedge clk);
        #1;
        check("b_2a_valid", valid_b, 1);
        check("b_2a_dout", dout_b, 7'h2A);
        fork
            send(1, 9'h078, 1'b1, 2'b11, 1'b0);
            begin : rst_branch
                int w;
                w = 0;
                while (busy_b !== 1'b1 && w < 2000) begin
                    @(negedge clk);
                    #1;
                    w++;
                end
                check("b_busy_seen", busy_b, 1);
                wait_ticks(4 * OS_B + 4);
                @(negedge clk);
                rst_n_b = 1'b0;
                @(negedge clk);
                #1;
                check("b_rst_dout", dout_b, 0);
                check("b_rst_valid", valid_b, 0);
                check("b_rst_perr", perr_b, 0);
                check("b_rst_ferr", ferr_b, 0);
                check("b_rst_ovr", ovr_b, 0);
                check("b_rst_busy", busy_b, 0);
                @(negedge clk);
                rst_n_b = 1'b1;
            end
        join
        @(negedge clk);
        #1;
        check("b_abandon_valid", valid_b, 0);
        check("b_abandon_busy", busy_b, 0);
        check("b_abandon_ovr", ovr_cnt_b, 0);
        send(1, 9'h055, 1'b1, 2'b11, 1'b0);
        @(negedge clk);
        #1;
        check("b_55_valid", valid_b, 1);
        check("b_55_dout", dout_b, 7'h55);
        check("b_55_perr", perr_b, 0);
        check("b_55_ferr", ferr_b, 0);
        pop(1, "b_55_pop");

        // Randomized frames on B with an always-ready consumer
        base = pop_q_b.size();
        exp_q.delete();
        ready_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data  = 9'($urandom_range(0, 127));
            pbit  = good_par(data, 7, 2) ^ ($urandom_range(0, 3) == 0);
            stops = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            send(1, data, pbit, stops, 1'b0);
            exp_q.push_back({model_perr(data, 7, 2, pbit), (stops != 2'b11), data});
            if (!stops[1]) begin
                wait_ticks($urandom_range(1, 2 * OS_B));
                drive_line(1, 1'b1);
                wait_ticks(OS_B);
            end else begin
                wait_ticks($urandom_range(0, 3));
            end
        end
        k = 0;
        while (valid_b !== 1'b0 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        ready_b = 1'b0;
        check("rnd_b_count", pop_q_b.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < pop_q_b.size()) check($sformatf("rnd_b_%0d", i), pop_q_b[base + i], exp_q[i]);
        end
        check("rnd_b_ovr", ovr_cnt_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
